// File: rtl/srff_access_arbiter.sv
// -----------------------------------------------------------------------------
// srff_access_arbiter
//
// Shares one set/reset flip-flop among N_REQ requesters. Arbitration is
// round-robin, starting from a pointer that moves to the requester after the
// last winner. The granted requester's set/clear request is turned into a
// clean pulse on the flop's s or r pin, held for PULSE_CYC cycles. s and r
// are never high together. A completion pulse is then returned to the
// winner.
//
// Optional feature (compile-time macro SRFF_ARB_VERIFY_EN):
//   defined   : a CHECK state follows DRIVE. It samples the flop's q and
//               flags a mismatch on o_err together with o_done.
//   undefined : DRIVE goes straight to DONE. o_err is always 0 and i_q is
//               ignored.
//
// Handshake: i_req is a level. It is sampled only in IDLE. The matching
// i_op bit is captured in the same cycle. After that the operation runs to
// completion whatever i_req does, and o_done pulses for exactly one cycle
// while o_gnt still selects the winner. A requester that keeps i_req high
// after o_done re-enters arbitration behind the others.
//
// Parameters:
//   N_REQ     : number of requesters (2..8)
//   PULSE_CYC : cycles s/r are held high per operation (1..15)
//
// Ports:
//   i_clk    : rising-edge clock, shared with the flop
//   i_rst    : synchronous active-high reset
//   i_req    : per-requester request level
//   i_op     : per-requester operation, 1 = set, 0 = clear
//   o_gnt    : one-hot grant, high from DRIVE through DONE
//   o_done   : one-cycle completion pulse
//   o_err    : readback mismatch, valid while o_done = 1
//   o_busy   : high whenever the FSM is not in IDLE
//   o_s      : to the flop's set input
//   o_r      : to the flop's reset input
//   i_q      : from the flop's q output
//   o_state  : debug view of the FSM state (0 IDLE, 1 DRIVE, 2 CHECK, 3 DONE)
// -----------------------------------------------------------------------------
module srff_access_arbiter #(
  parameter int N_REQ     = 4,
  parameter int PULSE_CYC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_op,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_done,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_s,
  output logic             o_r,
  input  logic             i_q,
  output logic [1:0]       o_state
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_idx;
  logic             r_op_q;
  logic [3:0]       r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic             r_s;
  logic             r_r;

  logic             w_found;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_ptr_next;

  // Round-robin scan. The loop runs from the highest offset down to the
  // lowest, so the requester closest to r_ptr is the last one written and
  // wins.
  always_comb begin
    logic [IW-1:0] v_j;
    v_j     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      v_j = IW'((32'(r_ptr) + 32'(i)) % N_REQ);
      if (i_req[v_j]) begin
        w_found = 1'b1;
        w_win   = v_j;
      end
    end
  end

  assign w_ptr_next = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifndef SRFF_ARB_VERIFY_EN
  // The readback pin has no function without the CHECK state.
  logic w_unused_q;
  assign w_unused_q = i_q;
`endif

  // Single FSM. Every output is a register that is loaded with the value
  // belonging to the state being entered. s and r are only ever loaded as
  // the complementary pair (op, ~op) or both zero, so s & r cannot occur.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_op_q  <= 1'b0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (w_found) begin
            r_idx   <= w_win;
            r_op_q  <= i_op[w_win];
            r_cnt   <= 4'(PULSE_CYC - 1);
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_busy  <= 1'b1;
            r_s     <= i_op[w_win];
            r_r     <= ~i_op[w_win];
            r_state <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (r_cnt == 4'd0) begin
            // The flop captures s/r on the edge that ends this cycle.
            r_s <= 1'b0;
            r_r <= 1'b0;
`ifdef SRFF_ARB_VERIFY_EN
            r_state <= ST_CHECK;
`else
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= ST_DONE;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
            r_s   <= r_op_q;
            r_r   <= ~r_op_q;
          end
        end

`ifdef SRFF_ARB_VERIFY_EN
        ST_CHECK: begin
          // q has been stable since the last DRIVE edge.
          r_err   <= (i_q != r_op_q);
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
`endif

        ST_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_busy  = r_busy;
  assign o_s     = r_s;
  assign o_r     = r_r;
  assign o_state = r_state;

endmodule

// File: tb/tb_srff_access_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for srff_access_arbiter. Two instances are used: dut (PULSE_CYC=1)
// for the arbitration tests and dut4 (PULSE_CYC=4) for pulse length and
// reset during DRIVE. Each instance drives its own behavioural SR flop.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_srff_access_arbiter;

  localparam int N  = 4;
  localparam int P  = 1;
  localparam int P4 = 4;
`ifdef SRFF_ARB_VERIFY_EN
  localparam int CHK       = 1;
  localparam bit STUCK_ERR = 1'b1;
`else
  localparam int CHK       = 0;
  localparam bit STUCK_ERR = 1'b0;
`endif
  localparam int LAT4 = P4 + 1 + CHK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut (PULSE_CYC = 1) ----------------
  logic [N-1:0] req = '0, op = '0, gnt;
  logic         done, err, busy, s, r, q_dut;
  logic [1:0]   st;
  logic         fq = 1'b0;
  logic         q_stuck = 1'b0;

  assign q_dut = q_stuck ? 1'b0 : fq;

  always @(posedge clk) begin
    if (s)      fq <= 1'b1;
    else if (r) fq <= 1'b0;
  end

  srff_access_arbiter #(.N_REQ(N), .PULSE_CYC(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_busy(busy),
    .o_s(s), .o_r(r), .i_q(q_dut), .o_state(st)
  );

  // ---------------- dut4 (PULSE_CYC = 4) ----------------
  logic [N-1:0] req4 = '0, op4 = '0, gnt4;
  logic         done4, err4, busy4, s4, r4;
  logic [1:0]   st4;
  logic         fq4 = 1'b0;

  always @(posedge clk) begin
    if (s4)      fq4 <= 1'b1;
    else if (r4) fq4 <= 1'b0;
  end

  srff_access_arbiter #(.N_REQ(N), .PULSE_CYC(P4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_op(op4),
    .o_gnt(gnt4), .o_done(done4), .o_err(err4), .o_busy(busy4),
    .o_s(s4), .o_r(r4), .i_q(fq4), .o_state(st4)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: expected grant per done pulse ----------------
  logic [N-1:0] exp_q[$];
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && done) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 32'(gnt), 32'h0);
      else                   check("sb_gnt", 32'(gnt), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the falling edge before the arbitration edge, with req/op set.
  // Walks DRIVE, (CHECK), DONE and the following IDLE cycle. With drop set,
  // req is released and op inverted during the first DRIVE cycle.
  task automatic expect_op(input string tag, input int idx, input bit opv,
                           input bit exp_err, input bit drop);
    logic [N-1:0] g;
    g = N'(1 << idx);
    exp_q.push_back(g);
    @(negedge clk);
    for (int c = 0; c < P; c++) begin
      check({tag, "_drv_gnt"},  32'(gnt), 32'(g));
      check({tag, "_drv_s"},    32'(s), 32'(opv));
      check({tag, "_drv_r"},    32'(r), 32'(!opv));
      check({tag, "_drv_done"}, 32'(done), 32'h0);
      check({tag, "_drv_busy"}, 32'(busy), 32'h1);
      if (c == 0 && drop) begin
        req = '0;
        op  = ~op;
      end
      @(negedge clk);
    end
`ifdef SRFF_ARB_VERIFY_EN
    check({tag, "_chk_gnt"},  32'(gnt), 32'(g));
    check({tag, "_chk_sr"},   32'({s, r}), 32'h0);
    check({tag, "_chk_done"}, 32'(done), 32'h0);
    @(negedge clk);
`endif
    check({tag, "_dn_gnt"},  32'(gnt), 32'(g));
    check({tag, "_dn_done"}, 32'(done), 32'h1);
    check({tag, "_dn_err"},  32'(err), 32'(exp_err));
    check({tag, "_dn_sr"},   32'({s, r}), 32'h0);
    check({tag, "_dn_busy"}, 32'(busy), 32'h1);
    @(negedge clk);
    check({tag, "_idle_gnt"},   32'(gnt), 32'h0);
    check({tag, "_idle_done"},  32'(done), 32'h0);
    check({tag, "_idle_busy"},  32'(busy), 32'h0);
    check({tag, "_idle_state"}, 32'(st), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, rcnt, scnt, dcnt;
    bit got;

    do_reset();
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_sr",    32'({s, r}), 32'h0);
    check("rst_state", 32'(st), 32'h0);
    mon_en = 1'b1;

    // Single set by requester 0.
    req = 4'b0001; op = 4'b0001;
    expect_op("t1", 0, 1'b1, 1'b0, 1'b1);
    check("t1_q", 32'(fq), 32'h1);

    // All four requesting clears continuously: 0,1,2,3,0 from ptr = 0.
    do_reset();
    req = 4'b1111; op = 4'b0000;
    expect_op("rr0", 0, 1'b0, 1'b0, 1'b0);
    expect_op("rr1", 1, 1'b0, 1'b0, 1'b0);
    expect_op("rr2", 2, 1'b0, 1'b0, 1'b0);
    expect_op("rr3", 3, 1'b0, 1'b0, 1'b0);
    expect_op("rr4", 0, 1'b0, 1'b0, 1'b1);
    check("rr_q", 32'(fq), 32'h0);

    // Move ptr to 3 (winner 2), then 0110 grants 1 first, then 2.
    req = 4'b0100; op = 4'b0100;
    expect_op("p3", 2, 1'b1, 1'b0, 1'b1);
    req = 4'b0110; op = 4'b0110;
    expect_op("w1", 1, 1'b1, 1'b0, 1'b0);
    expect_op("w2", 2, 1'b1, 1'b0, 1'b1);

    // q stuck at 0 while requester 3 sets the flop.
    q_stuck = 1'b1;
    req = 4'b1000; op = 4'b1000;
    expect_op("stuck", 3, 1'b1, STUCK_ERR, 1'b1);
    q_stuck = 1'b0;

    // Idempotent set while the flop already holds 1.
    req = 4'b0001; op = 4'b0001;
    expect_op("idem", 0, 1'b1, 1'b0, 1'b1);
    check("idem_q", 32'(fq), 32'h1);
    check("sb_left", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;

    // dut4: a clear from requester 1 must hold r for exactly four cycles.
    req4 = 4'b0010; op4 = 4'b0000;
    n = 0; rcnt = 0; scnt = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      req4 = '0;
      if (r4)    rcnt++;
      if (s4)    scnt++;
      if (done4) begin
        got = 1'b1;
        check("p4_gnt", 32'(gnt4), 32'h2);
      end
    end
    check("p4_done_seen", 32'(got), 32'h1);
    check("p4_latency",   32'(n), 32'(LAT4));
    check("p4_r_cycles",  32'(rcnt), 32'd4);
    check("p4_s_cycles",  32'(scnt), 32'd0);
    check("p4_q",         32'(fq4), 32'h0);
    @(negedge clk);

    // dut4: reset in the middle of a set.
    req4 = 4'b0001; op4 = 4'b0001;
    @(negedge clk);
    check("rd_gnt",  32'(gnt4), 32'h1);
    check("rd_s",    32'({s4, r4}), 32'h2);
    req4 = '0; op4 = '0;
    @(negedge clk);
    check("rd_s_hold", 32'({s4, r4}), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rd_gnt0",  32'(gnt4), 32'h0);
    check("rd_sr0",   32'({s4, r4}), 32'h0);
    check("rd_busy0", 32'(busy4), 32'h0);
    check("rd_done0", 32'(done4), 32'h0);
    check("rd_state", 32'(st4), 32'h0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) dcnt++;
    end
    check("rd_no_done", 32'(dcnt), 32'h0);
    check("rd_q_kept",  32'(fq4), 32'h1);

    // Random traffic: structural invariants on both instances.
    for (int i = 0; i < 10000; i++) begin
      req  = N'($urandom_range(0, 15));
      op   = N'($urandom_range(0, 15));
      req4 = N'($urandom_range(0, 15));
      op4  = N'($urandom_range(0, 15));
      q_stuck = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      check("inv_sr",       32'(s & r), 32'h0);
      check("inv_onehot",   32'($onehot0(gnt)), 32'h1);
      check("inv_done_gnt", 32'(done && (gnt == '0)), 32'h0);
      check("inv4_sr",      32'(s4 & r4), 32'h0);
      check("inv4_onehot",  32'($onehot0(gnt4)), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
